// File: rtl/im_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Holds the FSM state encoding, word geometry and the request range check.
package im_loader_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned LANE_W     = 8;
  localparam int unsigned WORD_W     = WORD_BYTES * LANE_W;
  localparam int unsigned IDX_W      = 2;
  localparam int unsigned CHECK_W    = 64;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  // End address is formed in a wide domain so base + 4*count cannot wrap.
  function automatic logic req_out_of_range(
    input logic [CHECK_W-1:0] base,
    input logic [15:0]        words,
    input logic [CHECK_W-1:0] mem_bytes
  );
    logic [CHECK_W-1:0] end_addr;
    end_addr = base + {{(CHECK_W-18){1'b0}}, words, 2'b00};
    return (end_addr > mem_bytes);
  endfunction

endpackage

// File: rtl/im_loader_byte_packer.sv
// Assembles four incoming bytes into one little-endian 32-bit word.
// Lane n of word_o holds the n-th byte accepted since the last clear.
module byte_packer
  import im_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic [LANE_W-1:0] data_i,
  output logic [WORD_W-1:0] word_o,
  output logic              full_o
);

  logic [WORD_BYTES-1:0][LANE_W-1:0] lanes_q;
  logic [WORD_BYTES-1:0][LANE_W-1:0] lanes_d;
  logic [IDX_W-1:0]                  idx_q;
  logic [IDX_W-1:0]                  idx_d;

  always_comb begin
    lanes_d = lanes_q;
    idx_d   = idx_q;
    if (clr_i) begin
      lanes_d = '0;
      idx_d   = '0;
    end else if (load_i) begin
      lanes_d[idx_q] = data_i;
      idx_d          = idx_q + 2'd1;
    end else begin
      lanes_d = lanes_q;
      idx_d   = idx_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lanes_q <= '0;
      idx_q   <= '0;
    end else begin
      lanes_q <= lanes_d;
      idx_q   <= idx_d;
    end
  end

  // The index wraps to 0 on the fourth load, so full marks the word-completing transfer.
  assign full_o = load_i && (idx_q == 2'd3);
  assign word_o = lanes_q;

endmodule

// File: rtl/im_loader.sv
// Streams bytes into instruction memory as aligned 32-bit words while holding the CPU busy.
// Requests are range-checked on start; rejected requests pulse err and leave memory untouched.
module im_loader
  import im_loader_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 16384,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       word_count,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_e            state_q;
  state_e            state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic [15:0]       cnt_q;
  logic [15:0]       cnt_d;
  logic              err_q;
  logic              err_d;

  logic              req_bad_s;
  logic              req_go_s;
  logic              clr_s;
  logic              load_s;
  logic              full_s;
  logic [WORD_W-1:0] word_s;

  assign req_bad_s = (base_addr[1:0] != 2'b00) ||
                     req_out_of_range(CHECK_W'(base_addr), word_count, CHECK_W'(MEM_BYTES));
  assign req_go_s  = (state_q == ST_IDLE) && start && !req_bad_s && (word_count != 16'd0);
  assign clr_s     = req_go_s;
  assign load_s    = (state_q == ST_COLLECT) && in_valid;

  byte_packer u_packer (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (clr_s),
    .load_i (load_s),
    .data_i (in_data),
    .word_o (word_s),
    .full_o (full_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !req_bad_s) begin
          state_d = (word_count == 16'd0) ? ST_DONE : ST_COLLECT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COLLECT: begin
        if (full_s) begin
          state_d = ST_WRITE;
        end else begin
          state_d = ST_COLLECT;
        end
      end
      ST_WRITE: begin
        if (cnt_q == 16'd1) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_COLLECT;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Address/count are only reloaded on an accepted request, so a start seen mid-load is inert.
  always_comb begin
    addr_d = addr_q;
    cnt_d  = cnt_q;
    err_d  = (state_q == ST_IDLE) && start && req_bad_s;
    if (req_go_s) begin
      addr_d = base_addr;
      cnt_d  = word_count;
    end else if (state_q == ST_WRITE) begin
      addr_d = addr_q + ADDR_W'(WORD_BYTES);
      cnt_d  = cnt_q - 16'd1;
    end else begin
      addr_d = addr_q;
      cnt_d  = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      cnt_q  <= 16'd0;
      err_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  always_comb begin
    in_ready = 1'b0;
    im_we    = 1'b0;
    im_addr  = '0;
    im_wdata = 32'd0;
    busy     = (state_q != ST_IDLE);
    done     = 1'b0;
    err      = err_q;
    case (state_q)
      ST_IDLE:    in_ready = 1'b0;
      ST_COLLECT: in_ready = 1'b1;
      ST_WRITE: begin
        im_we    = 1'b1;
        im_addr  = addr_q;
        im_wdata = word_s;
      end
      ST_DONE:    done = 1'b1;
      default:    in_ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_im_loader.sv
// Randomized bench for im_loader against a transaction-level reference of the load protocol.
`timescale 1ns/1ps
module tb_im_loader;

  localparam int MEM_BYTES = 16384;
  localparam int ADDR_W    = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] word_count;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        im_we;
  logic [31:0] im_addr;
  logic [31:0] im_wdata;
  logic        busy;
  logic        done;
  logic        err;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks  = 0;
  int  n_pass    = 0;
  int  done_seen = 0;
  int  err_seen  = 0;
  bit  mon_en    = 1'b0;

  im_loader #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .im_we      (im_we),
    .im_addr    (im_addr),
    .im_wdata   (im_wdata),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write monitor: every strobe must match the next expected word, idle bus must read zero.
  always @(negedge clk) begin
    if (mon_en) begin
      if (im_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("spurious_we", 64'(im_we), 64'd0);
        end else begin
          wr_t w;
          w = exp_q.pop_front();
          chk("im_addr", 64'(im_addr), 64'(w.addr));
          chk("im_wdata", 64'(im_wdata), 64'(w.data));
        end
      end else begin
        chk("idle_bus_zero", {im_addr, im_wdata}, 64'd0);
      end
      if (done === 1'b1) done_seen++;
      if (err === 1'b1) err_seen++;
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap, input bit poke);
    bit ok;
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      tick();
      chk("busy_in_gap", 64'(busy), 64'd1);
    end
    if (poke) begin
      in_valid   = 1'b0;
      start      = 1'b1;
      base_addr  = 32'($urandom_range(0, 1023)) * 32'd4;
      word_count = 16'($urandom_range(1, 4));
      tick();
      start = 1'b0;
    end
    in_valid = 1'b1;
    in_data  = b;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("busy_in_load", 64'(busy), 64'd1);
      if (in_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("in_ready_timeout", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("done_timeout", 64'(done), 64'd1);
    tick();
    tick();
  endtask

  task automatic do_load(input logic [31:0] base, input int cnt, input int max_gap,
                         input bit poke_en, input bit use_fixed, input logic [31:0] fixed_word);
    logic [31:0] word;
    longint      end_addr;
    bit          bad;
    int          d0;
    int          e0;
    wr_t         w;
    end_addr = longint'(base) + longint'(4 * cnt);
    bad = (base % 4 != 0) || (end_addr > longint'(MEM_BYTES));
    d0 = done_seen;
    e0 = err_seen;
    base_addr  = base;
    word_count = 16'(cnt);
    start      = 1'b1;
    tick();
    start      = 1'b0;
    base_addr  = $urandom;
    word_count = 16'($urandom);
    if (bad) begin
      @(negedge clk);
      chk("err_pulse", 64'(err), 64'd1);
      chk("busy_on_reject", 64'(busy), 64'd0);
      tick();
      tick();
      chk("err_count", 64'(err_seen - e0), 64'd1);
      chk("done_on_reject", 64'(done_seen - d0), 64'd0);
      chk("busy_after_reject", 64'(busy), 64'd0);
    end else begin
      for (int wi = 0; wi < cnt; wi++) begin
        word = (use_fixed && wi == 0) ? fixed_word : $urandom;
        w.addr = base + 32'(4 * wi);
        w.data = word;
        exp_q.push_back(w);
        for (int i = 0; i < 4; i++)
          send_byte(word[8*i +: 8], $urandom_range(0, max_gap),
                    poke_en && ($urandom_range(0, 5) == 0));
      end
      wait_done();
      chk("done_count", 64'(done_seen - d0), 64'd1);
      chk("no_err_on_load", 64'(err_seen - e0), 64'd0);
      chk("writes_drained", 64'(exp_q.size()), 64'd0);
      chk("busy_after_done", 64'(busy), 64'd0);
    end
  endtask

  task automatic reset_mid_load();
    logic [31:0] w0;
    logic [31:0] w1;
    wr_t         w;
    int          d0;
    w0 = $urandom;
    w1 = $urandom;
    d0 = done_seen;
    base_addr  = 32'h3000;
    word_count = 16'd2;
    start      = 1'b1;
    tick();
    start = 1'b0;
    w.addr = 32'h3000;
    w.data = w0;
    exp_q.push_back(w);
    for (int i = 0; i < 4; i++) send_byte(w0[8*i +: 8], $urandom_range(0, 2), 1'b0);
    for (int i = 0; i < 2; i++) send_byte(w1[8*i +: 8], $urandom_range(0, 2), 1'b0);
    // Reset collides with start and a valid byte; reset must win.
    rst        = 1'b1;
    start      = 1'b1;
    in_valid   = 1'b1;
    in_data    = 8'hAA;
    base_addr  = 32'h0000;
    word_count = 16'd1;
    tick();
    rst      = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    chk("rst_ctrl_zero", {59'd0, in_ready, im_we, busy, done, err}, 64'd0);
    chk("rst_bus_zero", {im_addr, im_wdata}, 64'd0);
    repeat (12) tick();
    chk("rst_stays_idle", 64'(busy), 64'd0);
    chk("rst_no_done", 64'(done_seen - d0), 64'd0);
    chk("rst_first_written", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] base;
    int          cnt;
    rst        = 1'b1;
    start      = 1'b0;
    in_valid   = 1'b0;
    in_data    = 8'd0;
    base_addr  = 32'd0;
    word_count = 16'd0;
    tick();
    tick();
    chk("reset_ctrl", {59'd0, in_ready, im_we, busy, done, err}, 64'd0);
    chk("reset_bus", {im_addr, im_wdata}, 64'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    tick();

    // Stream bytes 34,12,02,34 land little-endian as 0x34021234.
    do_load(32'h3000, 1, 0, 1'b0, 1'b1, 32'h34021234);
    do_load(32'h3000, 2, 3, 1'b0, 1'b0, 32'd0);
    do_load(32'h3002, 1, 0, 1'b0, 1'b0, 32'd0);
    do_load(32'h3FFC, 2, 0, 1'b0, 1'b0, 32'd0);
    do_load(32'h3FFC, 1, 1, 1'b0, 1'b0, 32'd0);
    do_load(32'h3000, 0, 0, 1'b0, 1'b0, 32'd0);
    reset_mid_load();
    do_load(32'h3000, 1, 1, 1'b0, 1'b0, 32'd0);
    do_load(32'h1000, 3, 2, 1'b1, 1'b0, 32'd0);

    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 3))
        0: begin base = 32'($urandom_range(0, 4095)) * 32'd4; cnt = $urandom_range(0, 4); end
        1: begin base = (32'($urandom_range(0, 4095)) * 32'd4) | 32'($urandom_range(1, 3));
                 cnt = $urandom_range(0, 3); end
        2: begin base = 32'(MEM_BYTES) - 32'($urandom_range(0, 4)) * 32'd4; cnt = $urandom_range(0, 5); end
        default: begin base = $urandom; cnt = $urandom_range(0, 3); end
      endcase
      do_load(base, cnt, $urandom_range(0, 3), ($urandom_range(0, 1) == 1), 1'b0, 32'd0);
    end

    tick();
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/im_loader.md
IM_LOADER -- requirements
Module: im_loader

Interface
REQ-001 Parameter MEM_BYTES, default 16384: byte capacity of the instruction memory being loaded.
REQ-002 Parameter ADDR_W, default 32: width of byte addresses.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle load request, honoured only in IDLE.
REQ-006 base_addr  input  ADDR_W  byte address of the first word to write.
REQ-007 word_count  input  16  number of 32-bit words to load.
REQ-008 in_data  input  8  incoming program byte.
REQ-009 in_valid  input  1  in_data is valid.
REQ-010 in_ready  output  1  loader accepts a byte this cycle; a transfer occurs when in_valid and in_ready are both high.
REQ-011 im_we  output  1  instruction-memory word write strobe.
REQ-012 im_addr  output  ADDR_W  word-aligned byte address of the write.
REQ-013 im_wdata  output  32  word to write; byte n of the stream occupies bits [8n+7:8n], so memory byte address+n receives stream byte n (little-endian).
REQ-014 busy  output  1  high in every state except IDLE; the CPU is held in stall while busy is high.
REQ-015 done  output  1  one-cycle pulse when a load completes.
REQ-016 err  output  1  one-cycle pulse when a start request is rejected.

Function
REQ-017 The states SHALL be IDLE, COLLECT, WRITE and DONE.
REQ-018 IDLE: in_ready=0; on start the loader SHALL validate base_addr and word_count in the same cycle.
REQ-019 base_addr[1:0]!=0, or base_addr+4*word_count>MEM_BYTES, SHALL pulse err on the next cycle and remain in IDLE with no writes.
REQ-020 A valid request with word_count==0 SHALL go to DONE, with no writes.
REQ-021 Any other valid request SHALL latch base_addr and word_count, clear the byte index, and go to COLLECT.
REQ-022 COLLECT: in_ready=1; each transfer SHALL place in_data in lane byte_idx and increment the 2-bit byte_idx; the 4th transfer SHALL move to WRITE.
REQ-023 Cycles with in_valid low SHALL leave all state unchanged; gaps of any length are legal.
REQ-024 WRITE: in_ready=0 and im_we=1 for exactly one cycle, with im_addr = current address and im_wdata = the assembled word.
REQ-025 After WRITE, the address SHALL advance by 4 and the remaining count SHALL decrement by 1; the loader SHALL go to DONE if the count reaches 0, otherwise back to COLLECT.
REQ-026 DONE: done=1 for one cycle, then return to IDLE.
REQ-027 Throughput at full rate SHALL be 5 cycles per word.
REQ-028 start asserted outside IDLE SHALL be ignored.
REQ-029 im_addr and im_wdata SHALL be 0 whenever im_we=0.
REQ-030 Bytes presented while in_ready=0 SHALL NOT be consumed.

Reset
REQ-031 On rst the loader SHALL enter IDLE with in_ready, im_we, im_addr, im_wdata, busy, done and err all 0, and byte_idx, address and count cleared.
REQ-032 rst during a load SHALL abort it: the partial word is discarded, no further writes occur, and words already written remain in memory.
REQ-033 rst SHALL take priority over start and over in_valid in the same cycle.

Structure
REQ-034 Package im_loader_pkg SHALL hold the state enumeration and the WORD_BYTES=4 constant.
REQ-035 A sub-module byte_packer SHALL hold the byte lanes and byte_idx (load, clear, full-flag); the FSM, counters and range check SHALL stay in im_loader.

Verification
REQ-036 start with base 0x3000, count 1, then bytes 34,12,02,34 -> one im_we, addr 0x3000, data 0x34021234, then done.
REQ-037 base 0x3000, count 2, with in_valid gaps of 0-3 cycles -> writes at 0x3000 and 0x3004 in order, one done pulse, busy high throughout.
REQ-038 base 0x3002 -> err pulse, no im_we, busy stays 0; base 0x3FFC with count 2 -> err.
REQ-039 count 0 -> done pulse, no im_we.
REQ-040 rst after 2 bytes of the second word -> all outputs 0 next cycle, no write at 0x3004; a new load then works normally.
REQ-041 start pulsed mid-load -> ignored; address sequence and count unchanged.
